// File: rtl/serial_write_buffer_if.sv
// serial_write_buffer_if
//   Bundles the parallel-load handshake and the serial output of the
//   serial write buffer. The master side (protocol engine / data path)
//   drives the load request, data and bit strobes; the slave side (the
//   buffer) returns the serial line and its idle/ready flag.
//
//   start       : one-cycle load request, honoured only while idle
//   write_sig   : one-cycle strobe, current bit consumed
//   data_in     : parallel word, low write_count bits are transmitted
//   write_count : number of bits to send (clamped to BUF_SIZE)
//   data_out    : registered serial data line
//   done_sig    : registered, high = idle and ready for start
interface serial_write_buffer_if #(
    parameter int BUF_SIZE = 8
);
    localparam int CTR_SIZE = $clog2(BUF_SIZE + 1);

    logic                start;
    logic                write_sig;
    logic [BUF_SIZE-1:0] data_in;
    logic [CTR_SIZE-1:0] write_count;
    logic                data_out;
    logic                done_sig;

    modport master (
        output start, write_sig, data_in, write_count,
        input  data_out, done_sig
    );

    modport slave (
        input  start, write_sig, data_in, write_count,
        output data_out, done_sig
    );
endinterface

// File: rtl/serial_write_buffer.sv
// serial_write_buffer
//   Loads up to BUF_SIZE parallel bits and presents them on a serial line,
//   most-significant (bit n-1) first, advancing one bit per write strobe.
//   The first bit is valid the cycle after start without a strobe; after
//   the last strobe the line returns to IDLE_LEVEL and done_sig rises one
//   cycle later.
//
//   sys_clk : system clock, all logic on the rising edge
//   rst     : synchronous, active-high reset
//   bus     : slave side of serial_write_buffer_if (start, write_sig,
//             data_in, write_count in; data_out, done_sig out)
module serial_write_buffer #(
    parameter int   BUF_SIZE   = 8,
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  logic                  sys_clk,
    input  logic                  rst,
    serial_write_buffer_if.slave  bus
);
    localparam int CTR_SIZE = $clog2(BUF_SIZE + 1);
    localparam logic [CTR_SIZE-1:0] BUF_SIZE_C = CTR_SIZE'(BUF_SIZE);
    localparam logic [CTR_SIZE-1:0] ONE_C      = CTR_SIZE'(1);

    typedef enum logic [1:0] {
        ST_RESET = 2'b00,
        ST_IDLE  = 2'b01,
        ST_WRITE = 2'b10
    } state_e;

    state_e              state_q,    state_d;
    logic [BUF_SIZE-1:0] shreg_q,    shreg_d;
    logic [CTR_SIZE-1:0] ctr_q,      ctr_d;
    logic                data_out_q, data_out_d;
    logic                done_q,     done_d;

    logic [CTR_SIZE-1:0] n_c;
    logic [BUF_SIZE-1:0] load_c;

    // Clamp the requested count and left-align the word so bit n-1 sits in
    // the MSB; the shift register then always emits from its top bit.
    always_comb begin
        n_c    = (bus.write_count > BUF_SIZE_C) ? BUF_SIZE_C : bus.write_count;
        load_c = bus.data_in << (BUF_SIZE_C - n_c);
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_d    = state_q;
        shreg_d    = shreg_q;
        ctr_d      = ctr_q;
        data_out_d = data_out_q;
        done_d     = done_q;

        case (state_q)
            ST_RESET: begin
                shreg_d    = '0;
                ctr_d      = '0;
                data_out_d = IDLE_LEVEL;
                done_d     = 1'b1;
                state_d    = ST_IDLE;
            end

            ST_IDLE: begin
                data_out_d = IDLE_LEVEL;
                done_d     = 1'b1;
                if (bus.start) begin
                    shreg_d    = load_c;
                    ctr_d      = n_c;
                    done_d     = 1'b0;
                    state_d    = ST_WRITE;
                    data_out_d = (n_c != '0) ? load_c[BUF_SIZE-1] : IDLE_LEVEL;
                end
            end

            ST_WRITE: begin
                if (ctr_q == '0) begin
                    // One-cycle tail after the final strobe before ready.
                    done_d     = 1'b1;
                    data_out_d = IDLE_LEVEL;
                    state_d    = ST_IDLE;
                end else if (bus.write_sig) begin
                    shreg_d    = shreg_q << 1;
                    ctr_d      = ctr_q - ONE_C;
                    // The bit below the MSB becomes the new MSB after the shift.
                    data_out_d = (ctr_q > ONE_C) ? shreg_q[BUF_SIZE-2] : IDLE_LEVEL;
                end
            end

            default: begin
                done_d     = 1'b0;
                data_out_d = IDLE_LEVEL;
                state_d    = ST_RESET;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        // NOTE: state is updated with non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (rst) begin
            state_q    <= ST_RESET;
            shreg_q    <= '0;
            ctr_q      <= '0;
            data_out_q <= IDLE_LEVEL;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            ctr_q      <= ctr_d;
            data_out_q <= data_out_d;
            done_q     <= done_d;
        end
    end

    assign bus.data_out = data_out_q;
    assign bus.done_sig = done_q;
endmodule

// File: tb/tb_serial_write_buffer.sv
// tb_serial_write_buffer
//   Directed bench for serial_write_buffer (BUF_SIZE=8, IDLE_LEVEL=1).
//   Inputs change and outputs are sampled on the falling clock edge.
module tb_serial_write_buffer;
    localparam int BUF_SIZE = 8;

    logic sys_clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    serial_write_buffer_if #(.BUF_SIZE(BUF_SIZE)) bus ();

    serial_write_buffer #(
        .BUF_SIZE   (BUF_SIZE),
        .IDLE_LEVEL (1'b1)
    ) dut (
        .sys_clk (sys_clk),
        .rst     (rst),
        .bus     (bus)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] actual,
                         input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(negedge sys_clk);
    endtask

    // Load a word, then strobe out every bit. gap = idle cycles before each
    // strobe (0 = back-to-back strobes). disturb = pulse start and change
    // data_in during the first gap cycle; neither may affect the transfer.
    task automatic send(input logic [7:0] data, input logic [3:0] count,
                        input int gap, input bit disturb);
        int         n;
        logic [7:0] rx;
        logic [7:0] mask;
        n  = (count > 4'd8) ? 8 : int'(count);
        rx = '0;
        mask = (n == 8) ? 8'hFF : 8'((1 << n) - 1);

        bus.data_in     = data;
        bus.write_count = count;
        bus.start       = 1'b1;
        tick();
        bus.start = 1'b0;
        check("first_bit", 32'(bus.data_out), (n > 0) ? 32'(data[n-1]) : 32'd1);
        check("busy_after_start", 32'(bus.done_sig), 32'd0);

        for (int k = 0; k < n; k++) begin
            for (int g = 0; g < gap; g++) begin
                if (disturb && k == 0 && g == 0) begin
                    bus.start   = 1'b1;
                    bus.data_in = ~data;
                    bus.write_count = 4'd2;
                end
                tick();
                bus.start = 1'b0;
                check("bit_hold", 32'(bus.data_out), 32'(data[n-1-k]));
            end
            rx = {rx[6:0], bus.data_out};
            bus.write_sig = 1'b1;
            tick();
            if (gap > 0) bus.write_sig = 1'b0;
            check("bit_next", 32'(bus.data_out), (k < n - 1) ? 32'(data[n-2-k]) : 32'd1);
        end
        bus.write_sig = 1'b0;

        if (n > 0) begin
            check("reassembled", 32'(rx), 32'(data & mask));
            check("busy_tail", 32'(bus.done_sig), 32'd0);
        end
        tick();
        check("done_after", 32'(bus.done_sig), 32'd1);
        check("idle_line", 32'(bus.data_out), 32'd1);
    endtask

    initial begin
        n_checks        = 0;
        n_fail          = 0;
        rst             = 1'b1;
        bus.start       = 1'b0;
        bus.write_sig   = 1'b0;
        bus.data_in     = '0;
        bus.write_count = '0;

        // Reset held for three cycles.
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_done", 32'(bus.done_sig), 32'd0);
            check("rst_line", 32'(bus.data_out), 32'd1);
        end
        rst = 1'b0;
        tick();
        check("post_rst_done", 32'(bus.done_sig), 32'd1);
        check("post_rst_line", 32'(bus.data_out), 32'd1);

        // write_sig while idle has no effect.
        bus.write_sig = 1'b1;
        tick();
        bus.write_sig = 1'b0;
        check("idle_strobe_done", 32'(bus.done_sig), 32'd1);
        check("idle_strobe_line", 32'(bus.data_out), 32'd1);

        // Full-width send, strobes three cycles apart.
        send(8'hA5, 4'd8, 2, 1'b0);
        // Partial send, back-to-back strobes: bits 0,1,1.
        send(8'hF3, 4'd3, 0, 1'b0);
        // Count above BUF_SIZE clamps to 8.
        send(8'hF3, 4'd12, 0, 1'b0);
        // Zero count: line stays idle, done after two cycles.
        send(8'hFF, 4'd0, 0, 1'b0);
        // start and data_in changes mid-transfer are ignored.
        send(8'h6B, 4'd6, 1, 1'b1);

        // Reset mid-transfer after 3 of 8 bits of 8'h3C.
        bus.data_in     = 8'h3C;
        bus.write_count = 4'd8;
        bus.start       = 1'b1;
        tick();
        bus.start = 1'b0;
        check("abort_bit0", 32'(bus.data_out), 32'd0);
        for (int k = 0; k < 3; k++) begin
            bus.write_sig = 1'b1;
            tick();
            bus.write_sig = 1'b0;
            tick();
        end
        check("abort_bit3", 32'(bus.data_out), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_line", 32'(bus.data_out), 32'd1);
        check("abort_done_low", 32'(bus.done_sig), 32'd0);
        tick();
        check("abort_done_high", 32'(bus.done_sig), 32'd1);
        check("abort_line_idle", 32'(bus.data_out), 32'd1);
        bus.write_sig = 1'b1;
        tick();
        bus.write_sig = 1'b0;
        check("abort_no_more_bits", 32'(bus.data_out), 32'd1);

        // Clean transfer after the abort: 1,0,0,0,0,0,0,1.
        send(8'h81, 4'd8, 1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/serial_write_buffer.md
Name: serial_write_buffer

Overview:
Transmit-side counterpart of the serial read buffer. It loads up to BUF_SIZE parallel bits and presents them on a serial line one bit at a time, advancing only on write strobes. It sits between protocol engines (SPI/UART-style bit-timing logic that generates write_sig) and the parallel data path. Bits go out most-significant-first, so a peer serial read buffer rebuilds the word with the last bit in the LSB.

Parameters:
BUF_SIZE, 8, maximum number of bits one transfer can carry (>= 2)
IDLE_LEVEL, 1'b1, level driven on data_out whenever no bit is being presented

Ports:
sys_clk  input  1  system clock; all logic on rising edge
rst  input  1  reset, synchronous, active-high
start  input  1  one-cycle request to load data_in/write_count and begin a transfer; sampled only in IDLE
write_sig  input  1  one-cycle strobe synchronous to sys_clk; current bit consumed, advance to next
data_in  input  BUF_SIZE  parallel data; the least significant write_count bits are transmitted
write_count  input  CTR_SIZE  number of bits to send, CTR_SIZE = clog2(BUF_SIZE+1)
data_out  output  1  registered serial data line
done_sig  output  1  registered; high = idle and ready for start, low = transfer in progress

Behaviour:
- Reset is synchronous and active-high on sys_clk/rst; polarity and synchronicity are fixed. No asynchronous reset path.
- While rst=1 at a rising edge:
  - state <= RESET
  - done_sig <= 0
  - data_out <= IDLE_LEVEL
  - start and write_sig are ignored.
- State RESET, entered for one cycle after rst drops:
  - clear the shift register and counter
  - data_out <= IDLE_LEVEL
  - done_sig <= 1
  - go to IDLE
- State IDLE:
  - data_out = IDLE_LEVEL, done_sig = 1, write_sig ignored.
  - On start=1:
    - n = min(write_count, BUF_SIZE); values above BUF_SIZE are clamped.
    - Shift register <= data_in << (BUF_SIZE-n), which aligns bit n-1 to the MSB.
    - ctr <= n, done_sig <= 0, go to WRITE.
    - data_out <= data_in[n-1] if n>0, else IDLE_LEVEL.
    - The first bit is therefore valid on the cycle after start, with no strobe needed.
- State WRITE:
  - If ctr==0: done_sig <= 1, data_out <= IDLE_LEVEL, go to IDLE. This gives a one-cycle tail after the last strobe.
  - Otherwise, on write_sig=1:
    - shift register shifts left one bit; ctr <= ctr-1
    - data_out <= next bit (new MSB) if ctr>1, else IDLE_LEVEL
  - Otherwise: hold all state; data_out is stable.
  - start is ignored in WRITE; it is neither queued nor used to restart.
- Latency:
  - start to first bit valid: 1 cycle.
  - Each write_sig to the next bit: 1 cycle.
  - Last write_sig to done_sig=1: 2 cycles. For n=0, start to done_sig=1 is 2 cycles.
- Ordering: bits leave as data_in[n-1], data_in[n-2], … data_in[0]. Bits above n-1 never appear on data_out.
- data_in and write_count are sampled only on the start cycle; later changes have no effect.
- Back-to-back write_sig on consecutive cycles is legal; each strobe consumes exactly one bit.
- Illegal state encoding: done_sig <= 0, data_out <= IDLE_LEVEL, go to RESET.
- rst asserted mid-transfer aborts at the next edge. data_out returns to IDLE_LEVEL and no further bits are emitted.
- done_sig and data_out are glitch-free registered outputs.

Test Plan:
1. Reset: hold rst 3 cycles, then release -> done_sig=0 and data_out=1 during rst; done_sig=1 one cycle after release; data_out stays 1.
2. Full-width send: BUF_SIZE=8, data_in=8'hA5, write_count=8, start, then 8 write_sig pulses spaced 3 cycles apart -> data_out sequence 1,0,1,0,0,1,0,1; data_out=1 (idle) after the 8th strobe; done_sig=1 two cycles after the 8th strobe.
3. Partial send with clamp and back-to-back strobes:
   - data_in=8'hF3, write_count=3, write_sig held high for 3 consecutive cycles -> bits 0,1,1 (data_in[2:0]); 3 strobes total.
   - Repeat with write_count=12 -> behaves exactly like count=8.
4. Zero count: data_in=8'hFF, write_count=0, start -> data_out stays 1 (idle); done_sig low 1 cycle, high 2 cycles after start.
5. Ignored inputs:
   - start pulse mid-transfer, and data_in changed after start -> transmitted bits unchanged.
   - write_sig in IDLE -> no effect.
   - Loopback into serial read buffer (read_sig=write_sig, read_count=write_count) -> reader data_out equals data_in masked to n bits.
6. Reset mid-transfer: after 3 of 8 bits of 8'h3C, pulse rst for 1 cycle -> data_out=1 next edge; done_sig 0 then 1; a new start with data_in=8'h81, write_count=8 sends 1,0,0,0,0,0,0,1 cleanly.
